// File: rtl/mp_top.sv
// Single-issue register-register ALU with a 32 x 32-bit register file.
// One instruction per clock; result and destination register update together.
module mp_top (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  output logic [31:0] result
);

  localparam logic [5:0] OpAdd = 6'd4;
  localparam logic [5:0] OpXor = 6'd5;
  localparam logic [5:0] OpNeg = 6'd6;
  localparam logic [5:0] OpAvg = 6'd7;
  localparam logic [5:0] OpAbs = 6'd8;
  localparam logic [5:0] OpNot = 6'd9;
  localparam logic [5:0] OpAnd = 6'd10;
  localparam logic [5:0] OpSub = 6'd11;
  localparam logic [5:0] OpOr  = 6'd12;
  localparam logic [5:0] OpMax = 6'd13;
  localparam logic [5:0] OpMin = 6'd14;

  // Power-on contents of the register file.
  function automatic logic [31:0] reset_value(input int unsigned idx);
    logic [31:0] v;
    case (idx)
      0:       v = 32'd0;
      1:       v = 32'd12996;
      2:       v = 32'd11490;
      3:       v = 32'd7070;
      4:       v = 32'd6026;
      5:       v = 32'd3322;
      6:       v = 32'd10344;
      7:       v = 32'd6734;
      8:       v = 32'd15834;
      9:       v = 32'd15314;
      10:      v = 32'd6000;
      11:      v = 32'd12196;
      12:      v = 32'd11290;
      13:      v = 32'd13350;
      14:      v = 32'd2086;
      15:      v = 32'd6734;
      16:      v = 32'd7430;
      17:      v = 32'd14102;
      18:      v = 32'd13200;
      19:      v = 32'd3264;
      20:      v = 32'd2368;
      21:      v = 32'd15846;
      22:      v = 32'd11710;
      23:      v = 32'd14736;
      24:      v = 32'd5338;
      25:      v = 32'd5544;
      26:      v = 32'd1852;
      27:      v = 32'd3898;
      28:      v = 32'd16252;
      29:      v = 32'd1048;
      30:      v = 32'd5642;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  logic [5:0]  opcode;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic [4:0]  dest;

  assign opcode = instruction[5:0];
  assign src1   = instruction[10:6];
  assign src2   = instruction[15:11];
  assign dest   = instruction[20:16];

  logic [31:0] regs [32];
  logic [31:0] op_a;
  logic [31:0] op_b;

  assign op_a = regs[src1];
  assign op_b = regs[src2];

  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] neg_a;
  logic [31:0] avg;
  logic        a_gt_b;

  assign sum    = op_a + op_b;
  assign diff   = op_a - op_b;
  assign neg_a  = 32'd0 - op_a;
  // Bias negative sums by one so the arithmetic shift truncates toward zero.
  assign avg    = $signed(sum + {31'd0, sum[31]}) >>> 1;
  assign a_gt_b = $signed(op_a) > $signed(op_b);

  logic        alu_valid;
  logic [31:0] alu_val;

  always_comb begin
    alu_valid = 1'b1;
    alu_val   = '0;
    case (opcode)
      OpAdd:   alu_val = sum;
      OpXor:   alu_val = op_a ^ op_b;
      OpNeg:   alu_val = neg_a;
      OpAvg:   alu_val = avg;
      OpAbs:   alu_val = ($signed(op_a) > 32'sd0) ? op_a : neg_a;
      OpNot:   alu_val = ~op_a;
      OpAnd:   alu_val = op_a & op_b;
      OpSub:   alu_val = diff;
      OpOr:    alu_val = op_a | op_b;
      OpMax:   alu_val = a_gt_b ? op_a : op_b;
      OpMin:   alu_val = a_gt_b ? op_b : op_a;
      default: alu_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= reset_value(i);
      end
      result <= '0;
    end else if (alu_valid) begin
      regs[dest] <= alu_val;
      result     <= alu_val;
    end
  end

endmodule

// File: tb/tb_mp_top.sv
// Self-checking bench for mp_top: directed sequences plus random instructions
// compared against a behavioural model of the register file and ALU.
module tb_mp_top;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic [31:0] result;

  int checks;
  int failures;

  mp_top dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .result      (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int InitVals [32] = '{
    0, 12996, 11490, 7070, 6026, 3322, 10344, 6734,
    15834, 15314, 6000, 12196, 11290, 13350, 2086, 6734,
    7430, 14102, 13200, 3264, 2368, 15846, 11710, 14736,
    5338, 5544, 1852, 3898, 16252, 1048, 5642, 0
  };

  int m_regs [32];
  int m_result;

  function automatic logic [31:0] enc(input int op, input int d, input int s1, input int s2);
    logic [31:0] w;
    w = '0;
    w[5:0]   = op[5:0];
    w[10:6]  = s1[4:0];
    w[15:11] = s2[4:0];
    w[20:16] = d[4:0];
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = InitVals[i];
    m_result = 0;
  endtask

  // Executes one instruction on the model using plain integer arithmetic.
  task automatic model_exec(input logic [31:0] ins);
    int a;
    int b;
    int r;
    int s;
    bit ok;
    a  = m_regs[ins[10:6]];
    b  = m_regs[ins[15:11]];
    ok = 1'b1;
    r  = 0;
    case (int'(ins[5:0]))
      4:  r = a + b;
      5:  r = a ^ b;
      6:  r = -a;
      7:  begin s = a + b; r = s / 2; end
      8:  r = (a > 0) ? a : -a;
      9:  r = ~a;
      10: r = a & b;
      11: r = a - b;
      12: r = a | b;
      13: r = (a > b) ? a : b;
      14: r = (a < b) ? a : b;
      default: ok = 1'b0;
    endcase
    if (ok) begin
      m_regs[ins[20:16]] = r;
      m_result = r;
    end
  endtask

  task automatic step(input logic [31:0] ins);
    instruction = ins;
    @(posedge clk);
    #1;
    model_exec(ins);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (result !== 32'd0) begin
      failures++;
      $display("FAIL reset_result got=%0h want=0", result);
    end
    // "or Ri,Ri,Ri" reads a register without changing it.
    for (int i = 0; i < 32; i++) begin
      step(enc(12, i, i, i));
      checks++;
      if ($signed(result) !== InitVals[i]) begin
        failures++;
        $display("FAIL reset_reg R%0d got=%0d want=%0d", i, $signed(result), InitVals[i]);
      end
    end
  endtask

  task automatic test_directed();
    logic [31:0] ins [23];
    int          exp [23];
    ins[0]  = enc(4, 31, 10, 3);   exp[0]  = 13070;
    ins[1]  = enc(5, 30, 10, 3);   exp[1]  = 3310;
    ins[2]  = enc(6, 31, 10, 0);   exp[2]  = -6000;
    ins[3]  = enc(7, 0, 10, 3);    exp[3]  = 6535;
    ins[4]  = enc(8, 0, 31, 0);    exp[4]  = 6000;
    ins[5]  = enc(9, 31, 10, 0);   exp[5]  = -6001;
    ins[6]  = enc(10, 30, 10, 3);  exp[6]  = 4880;
    ins[7]  = enc(11, 31, 10, 3);  exp[7]  = -1070;
    ins[8]  = enc(12, 30, 10, 3);  exp[8]  = 8190;
    ins[9]  = enc(13, 30, 10, 3);  exp[9]  = 7070;
    ins[10] = enc(14, 31, 10, 3);  exp[10] = 6000;
    ins[11] = enc(11, 31, 31, 18); exp[11] = -7200;
    ins[12] = enc(8, 5, 5, 0);     exp[12] = 3322;
    ins[13] = 32'h00057ACF;        exp[13] = 3322;
    ins[14] = enc(8, 5, 5, 0);     exp[14] = 3322;
    ins[15] = enc(6, 31, 31, 0);   exp[15] = 7200;
    ins[16] = enc(6, 0, 0, 0);     exp[16] = -6000;
    ins[17] = enc(13, 31, 31, 0);  exp[17] = 7200;
    ins[18] = enc(11, 0, 0, 0);    exp[18] = 0;
    ins[19] = enc(5, 0, 0, 24);    exp[19] = 5338;
    ins[20] = enc(6, 31, 24, 0);   exp[20] = -5338;
    ins[21] = enc(13, 0, 0, 24);   exp[21] = 5338;
    ins[22] = enc(14, 31, 31, 31); exp[22] = -5338;
    do_reset();
    for (int k = 0; k < 23; k++) begin
      step(ins[k]);
      checks++;
      if ($signed(result) !== exp[k]) begin
        failures++;
        $display("FAIL directed step %0d ins=%h got=%0d want=%0d", k, ins[k], $signed(result), exp[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // neg R31,R31 held for four edges alternates sign each edge.
    do_reset();
    step(enc(4, 31, 10, 0));
    for (int k = 0; k < 4; k++) begin
      step(enc(6, 31, 31, 0));
      checks++;
      if ($signed(result) !== (((k % 2) == 0) ? -6000 : 6000)) begin
        failures++;
        $display("FAIL back_to_back cycle %0d got=%0d", k, $signed(result));
      end
    end
  endtask

  task automatic test_boundary();
    do_reset();
    step(enc(9, 1, 0, 0));
    step(enc(6, 1, 1, 0));
    for (int k = 0; k < 31; k++) step(enc(4, 1, 1, 1));
    checks++;
    if (result !== 32'h80000000) begin
      failures++;
      $display("FAIL build_min got=%h want=80000000", result);
    end
    step(enc(8, 2, 1, 0));
    checks++;
    if (result !== 32'h80000000) begin
      failures++;
      $display("FAIL abs_min got=%h want=80000000", result);
    end
    step(enc(6, 2, 1, 0));
    checks++;
    if (result !== 32'h80000000) begin
      failures++;
      $display("FAIL neg_min got=%h want=80000000", result);
    end
    step(enc(9, 6, 0, 0));
    step(enc(6, 6, 6, 0));
    step(enc(4, 6, 6, 6));
    step(enc(9, 6, 6, 0));
    checks++;
    if ($signed(result) !== -3) begin
      failures++;
      $display("FAIL build_m3 got=%0d want=-3", $signed(result));
    end
    step(enc(7, 7, 6, 0));
    checks++;
    if ($signed(result) !== -1) begin
      failures++;
      $display("FAIL avg_m3_0 got=%0d want=-1", $signed(result));
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] held;
    do_reset();
    step(enc(6, 10, 10, 0));
    checks++;
    if ($signed(result) !== -6000) begin
      failures++;
      $display("FAIL mid_reset_write got=%0d want=-6000", $signed(result));
    end
    held = enc(4, 9, 10, 3);
    instruction = held;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (result !== 32'd0) begin
      failures++;
      $display("FAIL mid_reset_result got=%0d want=0", $signed(result));
    end
    rst_n = 1'b1;
    model_reset();
    step(held);
    checks++;
    if ($signed(result) !== 13070) begin
      failures++;
      $display("FAIL mid_reset_release got=%0d want=13070", $signed(result));
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    int          op;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) < 13) op = 4 + $urandom_range(0, 10);
      else if ($urandom_range(0, 1) == 1) op = $urandom_range(0, 3);
      else op = $urandom_range(15, 63);
      ins = $urandom;
      ins[5:0] = op[5:0];
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
        checks++;
        if (result !== 32'd0) begin
          failures++;
          $display("FAIL random_reset got=%h want=0", result);
        end
      end
      step(ins);
      checks++;
      if ($signed(result) !== m_result) begin
        failures++;
        $display("FAIL random step %0d ins=%h got=%0d want=%0d", k, ins, $signed(result), m_result);
      end
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    instruction = '0;
    model_reset();
    test_reset();
    test_directed();
    test_back_to_back();
    test_boundary();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
